// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply sequencing stage.
//   state_t : FSM encoding (IDLE/RUN/CORR/WRITE)
//   WORD_W  : architectural word width
package hilo_unit_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CORR  = 2'd2,
        WRITE = 2'd3
    } state_t;
endpackage

// File: rtl/hilo_unit_ucorr.sv
// hilo_ucorr: unsigned-correction adder for the HI half of a signed product.
// Turns signed {hi,lo} of a*b into the unsigned product by adding back b when
// a's sign bit was set and a when b's sign bit was set (modulo 2^32).
//   hi_in : HI half of the signed product
//   a, b  : operands that produced the product
//   en    : 1 = apply correction (unsigned op), 0 = pass hi_in through
//   hi_fix: corrected HI half
module hilo_ucorr
    import hilo_unit_pkg::*;
(
    input  logic [WORD_W-1:0] hi_in,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              en,
    output logic [WORD_W-1:0] hi_fix
);
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] add_a;

    assign add_b  = (en && a[WORD_W-1]) ? b : '0;
    assign add_a  = (en && b[WORD_W-1]) ? a : '0;
    assign hi_fix = hi_in + add_b + add_a;
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: holds operands on the external combinational multiplier for
// MUL_CYCLES cycles, captures the signed product, applies unsigned correction
// and writes HI/LO. Also handles mthi/mtlo direct writes and busy/done.
//   clk, clr_n        : clock, async active-low reset
//   start/op_unsigned/a/b : multiply request (sampled in IDLE only)
//   abort             : cancel in RUN/CORR
//   mul_a/mul_b       : held operands to mul_32; mul_hi/mul_lo : its product
//   hi_wr/lo_wr/wr_data : direct HI/LO writes (IDLE only)
//   hi_out/lo_out     : architectural HI/LO
//   busy              : state != IDLE; done : pulse during the WRITE cycle
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              op_unsigned,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              abort,
    output logic [WORD_W-1:0] mul_a,
    output logic [WORD_W-1:0] mul_b,
    input  logic [WORD_W-1:0] mul_hi,
    input  logic [WORD_W-1:0] mul_lo,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] hi_out,
    output logic [WORD_W-1:0] lo_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_t              state, next_state;
    logic [CW-1:0]       count;
    logic                op_uns;
    logic [2*WORD_W-1:0] prod;
    logic [WORD_W-1:0]   hi_fix;

    hilo_ucorr u_ucorr (
        .hi_in  (prod[2*WORD_W-1:WORD_W]),
        .a      (mul_a),
        .b      (mul_b),
        .en     (op_uns),
        .hi_fix (hi_fix)
    );

    always_comb begin
        next_state = state;
        case (state)
            // abort in IDLE suppresses a coincident start
            IDLE:    if (start && !abort) next_state = RUN;
            RUN:     if (abort) next_state = IDLE;
                     else if (count == '0) next_state = CORR;
            CORR:    next_state = abort ? IDLE : WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            count  <= '0;
            op_uns <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            prod   <= '0;
            hi_out <= '0;
            lo_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= next_state;
            // flopped decodes of next_state keep busy/done glitch-free
            busy  <= (next_state != IDLE);
            done  <= (next_state == WRITE);
            case (state)
                IDLE: begin
                    if (hi_wr) hi_out <= wr_data;
                    if (lo_wr) lo_out <= wr_data;
                    if (start && !abort) begin
                        mul_a  <= a;
                        mul_b  <= b;
                        op_uns <= op_unsigned;
                        count  <= CW'(MUL_CYCLES - 1);
                    end
                end
                RUN: begin
                    if (count == '0) prod <= {mul_hi, mul_lo};
                    else             count <= count - 1'b1;
                end
                CORR:  prod[2*WORD_W-1:WORD_W] <= hi_fix;
                WRITE: begin
                    hi_out <= prod[2*WORD_W-1:WORD_W];
                    lo_out <= prod[WORD_W-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0, op_unsigned = 1'b0, abort = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] mul_a, mul_b, mul_hi, mul_lo;
    logic        hi_wr = 1'b0, lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    // behavioural mul_32: signed 32x32 -> 64
    logic signed [63:0] sa, sb, sp;
    assign sa = {{32{mul_a[31]}}, mul_a};
    assign sb = {{32{mul_b[31]}}, mul_b};
    assign sp = sa * sb;
    assign mul_hi = sp[63:32];
    assign mul_lo = sp[31:0];

    hilo_unit #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op_unsigned(op_unsigned),
        .a(a), .b(b), .abort(abort), .mul_a(mul_a), .mul_b(mul_b),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .hi_wr(hi_wr), .lo_wr(lo_wr),
        .wr_data(wr_data), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: done marks the WRITE cycle; HI/LO land on the following edge
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = sb_q.pop_front();
                    @(posedge clk);
                    #1;
                    check("result_hi", hi_out, e[63:32]);
                    check("result_lo", lo_out, e[31:0]);
                end
            end
        end
    end

    // drive a request on one negedge, release on the next
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic u);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; op_unsigned = u;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #12;
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mul_a", mul_a, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;

        // signed -3*5, also measure busy length
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        issue(32'hFFFFFFFD, 32'd5, 1'b0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin cnt++; @(negedge clk); end
        check("busy_cycles", 32'(cnt), 32'(MC + 2));
        @(negedge clk);

        // unsigned vs signed all-ones, and sign-bit-only operand
        sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); wait_idle();
        sb_q.push_back({32'h00000000, 32'h00000001});
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();
        sb_q.push_back({32'h00000001, 32'h00000000});
        issue(32'h80000000, 32'd2, 1'b1); wait_idle();
        sb_q.push_back({32'hFFFFFFFF, 32'h00000000});
        issue(32'h80000000, 32'd2, 1'b0); wait_idle();

        // busy interlock: second start and mthi dropped (HI currently FFFFFFFF)
        sb_q.push_back({32'h0, 32'd12});
        issue(32'd3, 32'd4, 1'b0);
        start = 1'b1; a = 32'd7; b = 32'd7; hi_wr = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0;
        check("busy_hold_mul_a", mul_a, 32'd3);
        check("busy_hi_wr_dropped", hi_out, 32'hFFFFFFFF);
        wait_idle();

        // abort in RUN
        hi_wr = 1'b1; wr_data = 32'hAAAA0000;
        @(negedge clk);
        hi_wr = 1'b0;
        check("preset_hi", hi_out, 32'hAAAA0000);
        issue(32'd6, 32'd7, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (MC + 3) @(negedge clk);
        check("abort_hi", hi_out, 32'hAAAA0000);
        check("abort_lo", lo_out, 32'd12);
        sb_q.push_back({32'h0, 32'd42});
        issue(32'd6, 32'd7, 1'b0); wait_idle();

        // abort in IDLE blocks a coincident start
        abort = 1'b1;
        issue(32'd9, 32'd9, 1'b0);
        abort = 1'b0;
        check("idle_abort_blocks", 32'(busy), 32'd0);

        // same-cycle start and mthi
        sb_q.push_back({32'h0, 32'd6});
        @(negedge clk);
        start = 1'b1; a = 32'd2; b = 32'd3; op_unsigned = 1'b0;
        hi_wr = 1'b1; wr_data = 32'h55;
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0;
        check("same_cycle_hi_wr", hi_out, 32'h55);
        check("same_cycle_busy", 32'(busy), 32'd1);
        wait_idle();

        // reset during CORR
        issue(32'h10000, 32'h10000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("rst_mid_hi", hi_out, 32'h0);
        check("rst_mid_lo", lo_out, 32'h0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (MC + 4) @(negedge clk);
        check("rst_release_hi", hi_out, 32'h0);

        // direct writes in IDLE
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthi", hi_out, 32'hDEADBEEF);
        check("mtlo", lo_out, 32'hDEADBEEF);
        check("mt_done", 32'(done), 32'd0);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
